// File: rtl/reg_port_arbiter_if.sv
// Requester, response, clear-control and register-file pin bundle for reg_port_arbiter.
interface reg_port_arbiter_if #(
  parameter int W = 8,
  parameter int D = 3
);
  logic         Req0Valid, Req1Valid;
  logic         Req0Write, Req1Write;
  logic [D-1:0] Req0Addr, Req1Addr;
  logic [W-1:0] Req0Data, Req1Data;
  logic         Req0Ready, Req1Ready;
  logic         Rsp0Valid, Rsp1Valid;
  logic [W-1:0] RspData;
  logic         ClrStart;
  logic         ClrBusy;
  logic         ClrDone;
  logic         RfWriteEn;
  logic [D-1:0] RfWaddr;
  logic [W-1:0] RfDataIn;
  logic [D-1:0] RfRaddrA;
  logic [W-1:0] RfDataOutA;

  modport slave (
    input  Req0Valid, Req1Valid, Req0Write, Req1Write,
    input  Req0Addr, Req1Addr, Req0Data, Req1Data,
    output Req0Ready, Req1Ready, Rsp0Valid, Rsp1Valid, RspData,
    input  ClrStart,
    output ClrBusy, ClrDone,
    output RfWriteEn, RfWaddr, RfDataIn, RfRaddrA,
    input  RfDataOutA
  );

  modport master (
    output Req0Valid, Req1Valid, Req0Write, Req1Write,
    output Req0Addr, Req1Addr, Req0Data, Req1Data,
    input  Req0Ready, Req1Ready, Rsp0Valid, Rsp1Valid, RspData,
    output ClrStart,
    input  ClrBusy, ClrDone,
    input  RfWriteEn, RfWaddr, RfDataIn, RfRaddrA,
    output RfDataOutA
  );
endinterface

// File: rtl/reg_port_arbiter.sv
// Two-requester arbiter/sequencer for the register file write port and read port A, with a clear sequence.
// Define REGARB_FIXED_PRIO_EN for fixed priority (requester 0 always wins); default is round-robin.
module reg_port_arbiter #(
  parameter int W = 8,
  parameter int D = 3
) (
  input logic            Clk,
  input logic            Reset,
  reg_port_arbiter_if.slave bus
);

  typedef enum logic [0:0] {IDLE, CLEAR} state_t;

  localparam logic [D:0] CLR_END = {1'b1, {D{1'b0}}};

  state_t       state_q, state_d;
  logic [D:0]   clr_cnt_q, clr_cnt_d;
  logic         clr_done_q, clr_done_d;
  logic         iss_valid_q, iss_valid_d;
  logic         iss_write_q, iss_write_d;
  logic         iss_clr_q, iss_clr_d;
  logic         iss_id_q, iss_id_d;
  logic [D-1:0] iss_addr_q, iss_addr_d;
  logic [W-1:0] iss_data_q, iss_data_d;
  logic         rsp0_valid_q, rsp0_valid_d;
  logic         rsp1_valid_q, rsp1_valid_d;
  logic [W-1:0] rsp_data_q, rsp_data_d;
  logic         grant0, grant1;
  logic         prio0;

`ifdef REGARB_FIXED_PRIO_EN
  assign prio0 = 1'b1;
`else
  logic last_grant_q, last_grant_d;
  // Requester 0 wins a conflict exactly when requester 1 took the previous grant.
  assign prio0 = last_grant_q;
`endif

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    clr_done_d   = 1'b0;
    iss_valid_d  = 1'b0;
    iss_write_d  = iss_write_q;
    iss_clr_d    = 1'b0;
    iss_id_d     = iss_id_q;
    iss_addr_d   = iss_addr_q;
    iss_data_d   = iss_data_q;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    rsp_data_d   = '0;
    grant0       = 1'b0;
    grant1       = 1'b0;
`ifndef REGARB_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.ClrStart) begin
          state_d     = CLEAR;
          iss_valid_d = 1'b1;
          iss_write_d = 1'b1;
          iss_clr_d   = 1'b1;
          iss_addr_d  = '0;
          iss_data_d  = '0;
          clr_cnt_d   = {{D{1'b0}}, 1'b1};
        end else if (!Reset) begin
          grant0 = bus.Req0Valid && (!bus.Req1Valid || prio0);
          grant1 = bus.Req1Valid && (!bus.Req0Valid || !prio0);
          if (grant0 || grant1) begin
            iss_valid_d  = 1'b1;
            iss_id_d     = grant1;
            iss_write_d  = grant1 ? bus.Req1Write : bus.Req0Write;
            iss_addr_d   = grant1 ? bus.Req1Addr  : bus.Req0Addr;
            iss_data_d   = grant1 ? bus.Req1Data  : bus.Req0Data;
`ifndef REGARB_FIXED_PRIO_EN
            last_grant_d = grant1;
`endif
          end
        end
      end
      CLEAR: begin
        // The counter runs one ahead of the issued address so reaching 2**D marks the last write in flight.
        if (clr_cnt_q == CLR_END) begin
          state_d    = IDLE;
          clr_done_d = 1'b1;
          clr_cnt_d  = '0;
        end else begin
          iss_valid_d = 1'b1;
          iss_write_d = 1'b1;
          iss_clr_d   = 1'b1;
          iss_addr_d  = clr_cnt_q[D-1:0];
          iss_data_d  = '0;
          clr_cnt_d   = clr_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (iss_valid_q && !iss_clr_q) begin
      rsp0_valid_d = !iss_id_q;
      rsp1_valid_d = iss_id_q;
      rsp_data_d   = iss_write_q ? '0 : bus.RfDataOutA;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      clr_cnt_q    <= '0;
      clr_done_q   <= 1'b0;
      iss_valid_q  <= 1'b0;
      iss_write_q  <= 1'b0;
      iss_clr_q    <= 1'b0;
      iss_id_q     <= 1'b0;
      iss_addr_q   <= '0;
      iss_data_q   <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp_data_q   <= '0;
`ifndef REGARB_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      clr_done_q   <= clr_done_d;
      iss_valid_q  <= iss_valid_d;
      iss_write_q  <= iss_write_d;
      iss_clr_q    <= iss_clr_d;
      iss_id_q     <= iss_id_d;
      iss_addr_q   <= iss_addr_d;
      iss_data_q   <= iss_data_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp_data_q   <= rsp_data_d;
`ifndef REGARB_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign bus.Req0Ready = grant0;
  assign bus.Req1Ready = grant1;
  assign bus.Rsp0Valid = rsp0_valid_q;
  assign bus.Rsp1Valid = rsp1_valid_q;
  assign bus.RspData   = rsp_data_q;
  assign bus.ClrBusy   = (state_q == CLEAR);
  assign bus.ClrDone   = clr_done_q;
  assign bus.RfWriteEn = iss_valid_q && iss_write_q;
  assign bus.RfWaddr   = iss_addr_q;
  assign bus.RfRaddrA  = iss_addr_q;
  assign bus.RfDataIn  = iss_data_q;

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Directed bench for reg_port_arbiter with a register-file model and a response scoreboard.
module tb_reg_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cycle_cnt = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic       id;
    logic [7:0] data;
    int         due;
  } rsp_t;

  rsp_t       sb_q[$];
  logic [7:0] shadow [8];
  logic [7:0] rf_mem [8];

  reg_port_arbiter_if #(.W(8), .D(3)) bus ();

  reg_port_arbiter #(.W(8), .D(3)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Register file: synchronous write, combinational read port A.
  always @(posedge clk) if (bus.RfWriteEn) rf_mem[bus.RfWaddr] <= bus.RfDataIn;
  assign bus.RfDataOutA = rf_mem[bus.RfRaddrA];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic recordAccept(input logic id, input logic wr, input logic [2:0] a, input logic [7:0] d);
    rsp_t e;
    e.id  = id;
    e.due = cycle_cnt + 2;
    if (wr) begin
      shadow[a] = d;
      e.data    = 8'h00;
    end else begin
      e.data = shadow[a];
    end
    sb_q.push_back(e);
  endtask

  // Drives one cycle of inputs just after the edge, then returns at the falling edge for checks.
  task automatic applyStimulus(input logic rst_i, input logic clr,
                               input logic v0, input logic w0, input logic [2:0] a0, input logic [7:0] d0,
                               input logic v1, input logic w1, input logic [2:0] a1, input logic [7:0] d1);
    @(posedge clk);
    #1;
    rst           = rst_i;
    bus.ClrStart  = clr;
    bus.Req0Valid = v0;
    bus.Req0Write = w0;
    bus.Req0Addr  = a0;
    bus.Req0Data  = d0;
    bus.Req1Valid = v1;
    bus.Req1Write = w1;
    bus.Req1Addr  = a1;
    bus.Req1Data  = d1;
    @(negedge clk);
    if (bus.Req0Valid && bus.Req0Ready) recordAccept(1'b0, w0, a0, d0);
    if (bus.Req1Valid && bus.Req1Ready) recordAccept(1'b1, w1, a1, d1);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
  endtask

  always @(negedge clk) begin
    if (bus.Rsp0Valid || bus.Rsp1Valid) begin
      if (sb_q.size() == 0) begin
        checkOutput("rsp_unexpected", {30'd0, bus.Rsp1Valid, bus.Rsp0Valid}, 32'd0);
      end else begin
        rsp_t e;
        e = sb_q.pop_front();
        checkOutput("rsp_owner", {30'd0, bus.Rsp1Valid, bus.Rsp0Valid}, e.id ? 32'd2 : 32'd1);
        checkOutput("rsp_data", {24'd0, bus.RspData}, {24'd0, e.data});
        checkOutput("rsp_cycle", cycle_cnt, e.due);
      end
    end
  end

  initial begin
    bus.ClrStart  = 1'b0;
    bus.Req0Valid = 1'b0;
    bus.Req0Write = 1'b0;
    bus.Req0Addr  = '0;
    bus.Req0Data  = '0;
    bus.Req1Valid = 1'b0;
    bus.Req1Write = 1'b0;
    bus.Req1Addr  = '0;
    bus.Req1Data  = '0;
    for (int k = 0; k < 8; k++) shadow[k] = 8'h00;

    // Reset held with a request pending: nothing granted, all outputs at reset values.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00);
    checkOutput("reset_outputs",
                {bus.Req0Ready, bus.Req1Ready, bus.Rsp0Valid, bus.Rsp1Valid, bus.RspData, bus.ClrBusy,
                 bus.ClrDone, bus.RfWriteEn, bus.RfWaddr, bus.RfRaddrA, bus.RfDataIn}, 32'd0);

    // Write addr 3 then read it back the next cycle.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 8'h5A, 1'b0, 1'b0, 3'd0, 8'h00);
    checkOutput("raw_wr_ready", {31'd0, bus.Req0Ready}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
    checkOutput("raw_rd_ready", {31'd0, bus.Req0Ready}, 32'd1);
    checkOutput("raw_issue_wr", {20'd0, bus.RfWriteEn, bus.RfWaddr, bus.RfDataIn}, {20'd0, 1'b1, 3'd3, 8'h5A});
    idleCycle();
    checkOutput("raw_issue_rd", {28'd0, bus.RfWriteEn, bus.RfRaddrA}, {28'd0, 1'b0, 3'd3});
    idleCycle();

    // Preload every register from requester 1.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 3'(k), 8'(17 * (k + 1)));
      checkOutput("preload1_ready", {31'd0, bus.Req1Ready}, 32'd1);
    end

    // Both requesters continuously valid; requester 1 took the last grant.
    for (int i = 0; i < 4; i++) begin
      logic g1;
`ifdef REGARB_FIXED_PRIO_EN
      g1 = 1'b0;
`else
      g1 = (i % 2) == 1;
`endif
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 8'h00, 1'b1, 1'b0, 3'd2, 8'h00);
      checkOutput("prio_grant", {30'd0, bus.Req1Ready, bus.Req0Ready}, g1 ? 32'd2 : 32'd1);
    end
    idleCycle();
    idleCycle();

    // Clear with requester 1 waiting, and a second ClrStart that must be ignored.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, (i == 0) || (i == 3), 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd5, 8'h00);
      if (i == 0) for (int k = 0; k < 8; k++) shadow[k] = 8'h00;
      checkOutput("clr_ready1", {31'd0, bus.Req1Ready}, {31'd0, (i == 9)});
      checkOutput("clr_busy", {31'd0, bus.ClrBusy}, {31'd0, (i >= 1 && i <= 8)});
      checkOutput("clr_done", {31'd0, bus.ClrDone}, {31'd0, (i == 9)});
      if (i >= 1 && i <= 8)
        checkOutput("clr_write", {20'd0, bus.RfWriteEn, bus.RfWaddr, bus.RfDataIn}, {20'd0, 1'b1, 3'(i - 1), 8'h00});
    end
    idleCycle();
    checkOutput("clr_done_once", {31'd0, bus.ClrDone}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 3'(k), 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
      checkOutput("post_clr_ctl", {30'd0, bus.ClrBusy, bus.ClrDone}, 32'd0);
    end
    idleCycle();
    idleCycle();

    // Preload again, then reset four cycles into a clear.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 3'(k), 8'(17 * (k + 1)), 1'b0, 1'b0, 3'd0, 8'h00);
      checkOutput("preload0_ready", {31'd0, bus.Req0Ready}, 32'd1);
    end
    idleCycle();
    idleCycle();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(i == 4, i == 0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
      if (i >= 1)
        checkOutput("rstclr_write", {20'd0, bus.RfWriteEn, bus.RfWaddr, bus.RfDataIn}, {20'd0, 1'b1, 3'(i - 1), 8'h00});
    end
    sb_q.delete();
    for (int k = 0; k < 4; k++) shadow[k] = 8'h00;
    idleCycle();
    checkOutput("rstclr_outputs",
                {bus.Req0Ready, bus.Req1Ready, bus.Rsp0Valid, bus.Rsp1Valid, bus.RspData, bus.ClrBusy,
                 bus.ClrDone, bus.RfWriteEn, bus.RfWaddr, bus.RfRaddrA, bus.RfDataIn}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 3'(k), 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
      checkOutput("rstclr_rd_ready", {31'd0, bus.Req0Ready}, 32'd1);
      checkOutput("rstclr_ctl", {30'd0, bus.ClrBusy, bus.ClrDone}, 32'd0);
    end
    idleCycle();
    idleCycle();
    idleCycle();

    // A read in flight when reset arrives produces no response.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 3'd6, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
    checkOutput("rstrd_ready", {31'd0, bus.Req0Ready}, 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
    sb_q.delete();
    idleCycle();
    checkOutput("rstrd_no_rsp", {30'd0, bus.Rsp1Valid, bus.Rsp0Valid}, 32'd0);
    idleCycle();
    idleCycle();

    checkOutput("sb_drained", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
